// File: rtl/vector_register_file_mt_pkg.sv
// Shared sizing defaults and state encoding
// for the multithreaded vector register file.
package vector_register_file_mt_pkg;

    localparam int VRF_NUM_LANES   = 16;
    localparam int VRF_LANE_WIDTH  = 32;
    localparam int VRF_NUM_REGS    = 32;
    localparam int VRF_NUM_THREADS = 4;

    localparam int VRF_REG_IDX_WIDTH = $clog2(VRF_NUM_REGS);
    localparam int VRF_THREAD_IDX_WIDTH =
        (VRF_NUM_THREADS > 1) ? $clog2(VRF_NUM_THREADS) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } vrf_state_t;

endpackage

// File: rtl/vector_register_file_mt_lane_bank.sv
// One lane of the register file: storage, two
// synchronous read ports and write-to-read bypass.
module vrf_lane_bank #(
    parameter int LANE_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LANE_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [LANE_WIDTH-1:0] rd_data1,
    output logic [LANE_WIDTH-1:0] rd_data2
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [LANE_WIDTH-1:0] mem [ENTRIES];
    logic [LANE_WIDTH-1:0] rd_next1;
    logic [LANE_WIDTH-1:0] rd_next2;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_next1 = mem[rd_addr1];
        rd_next2 = mem[rd_addr2];
        if (wr_en && wr_addr == rd_addr1)
            rd_next1 = wr_data;
        if (wr_en && wr_addr == rd_addr2)
            rd_next2 = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (rd_en) begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
        end
    end

endmodule

// File: rtl/vector_register_file_mt.sv
// Multithreaded lane-masked vector register file
// with bypass and a post-reset clear sweep.
module vector_register_file_mt
    import vector_register_file_mt_pkg::*;
#(
    parameter int NUM_LANES        = VRF_NUM_LANES,
    parameter int LANE_WIDTH       = VRF_LANE_WIDTH,
    parameter int NUM_REGS         = VRF_NUM_REGS,
    parameter int NUM_THREADS      = VRF_NUM_THREADS,
    parameter int REG_IDX_WIDTH    = $clog2(NUM_REGS),
    parameter int THREAD_IDX_WIDTH =
        (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            rf_ready,
    input  logic                            ds_read_en,
    input  logic [THREAD_IDX_WIDTH-1:0]     ds_thread_id,
    input  logic [REG_IDX_WIDTH-1:0]        ds_vector_sel1,
    input  logic [REG_IDX_WIDTH-1:0]        ds_vector_sel2,
    output logic [NUM_LANES*LANE_WIDTH-1:0] vector_value1,
    output logic [NUM_LANES*LANE_WIDTH-1:0] vector_value2,
    input  logic                            wb_enable_vector_writeback,
    input  logic [THREAD_IDX_WIDTH-1:0]     wb_thread_id,
    input  logic [REG_IDX_WIDTH-1:0]        wb_writeback_reg,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] wb_writeback_value,
    input  logic [NUM_LANES-1:0]            wb_writeback_mask
);

    localparam int ADDR_WIDTH = THREAD_IDX_WIDTH + REG_IDX_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(NUM_THREADS * NUM_REGS - 1);

    vrf_state_t            state;
    vrf_state_t            state_next;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic                  clearing;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic                  rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clear_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clear_idx <= clear_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR: if (clear_idx == LAST_IDX) state_next = READY;
            READY: state_next = READY;
        endcase
    end

    always_comb begin
        rf_ready = (state == READY);
        clearing = (state == CLEAR);
    end

    // The sweep borrows the write port; writeback is locked out until ready.
    assign wr_addr  = clearing ? clear_idx
                               : {wb_thread_id, wb_writeback_reg};
    assign rd_addr1 = {ds_thread_id, ds_vector_sel1};
    assign rd_addr2 = {ds_thread_id, ds_vector_sel2};
    assign rd_en    = ds_read_en & rf_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic                  lane_we;
        logic [LANE_WIDTH-1:0] lane_wd;

        assign lane_we = clearing | (wb_enable_vector_writeback
                                     & wb_writeback_mask[i] & rf_ready);
        assign lane_wd = clearing ? '0
                       : wb_writeback_value[i*LANE_WIDTH +: LANE_WIDTH];

        vrf_lane_bank #(
            .LANE_WIDTH(LANE_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (lane_we),
            .wr_addr (wr_addr),
            .wr_data (lane_wd),
            .rd_en   (rd_en),
            .rd_addr1(rd_addr1),
            .rd_addr2(rd_addr2),
            .rd_data1(vector_value1[i*LANE_WIDTH +: LANE_WIDTH]),
            .rd_data2(vector_value2[i*LANE_WIDTH +: LANE_WIDTH])
        );
    end

endmodule
